// File: rtl/mag_comp_pkg.sv
// -----------------------------------------------------------------------------
// mag_comp_pkg
//   Shared types for the sequential magnitude comparator.
//   - state_t : FSM state encoding (IDLE, CMP, DONE)
//   - res_t   : per-slice compare outcome (GT, EQ, LT)
//   - classify: folds the slice comparator outputs into a res_t
// -----------------------------------------------------------------------------
package mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GT = 2'd0,
    EQ = 2'd1,
    LT = 2'd2
  } res_t;

  function automatic res_t classify(input logic gt, input logic eq);
    if (gt)      return GT;
    else if (eq) return EQ;
    else         return LT;
  endfunction

endpackage

// File: rtl/mag_comp_seq_comp_digit.sv
// -----------------------------------------------------------------------------
// comp_digit
//   Combinational DIGIT-bit unsigned magnitude compare.
//   Ports:
//     a, b : DIGIT-bit operand slices
//     gt   : a > b
//     eq   : a == b
//     lt   : a < b
// -----------------------------------------------------------------------------
module comp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a >  b);
  assign eq = (a == b);
  assign lt = (a <  b);

endmodule

// File: rtl/mag_comp_seq.sv
// -----------------------------------------------------------------------------
// mag_comp_seq
//   Multi-cycle WIDTH-bit magnitude comparator. Compares one DIGIT-bit slice
//   per cycle, most significant slice first, and stops on the first slice
//   that differs. Supports unsigned and two's-complement ordering.
//
//   Parameters:
//     WIDTH : operand width; must be a multiple of DIGIT and >= DIGIT
//     DIGIT : bits compared per cycle (NDIG = WIDTH/DIGIT slices)
//
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     start       : request a compare (only sampled in IDLE)
//     signed_mode : 1 = two's-complement ordering, 0 = unsigned
//     a, b        : operands, captured when start is accepted
//     busy        : high while a compare is in flight (CMP and DONE)
//     done        : one-cycle pulse, flags/digits valid from this cycle
//     a_greater, a_equal, a_lesser : one-hot result, held until next start
//     digits      : number of slices examined for the last result
//
//   Handshake: start is a request that is accepted on any rising edge where
//   the FSM is IDLE; it is ignored (not queued) while busy. Acceptance
//   captures a, b and signed_mode, so later input changes have no effect.
//   Completion is signalled by a single-cycle done pulse; the result stays
//   on the flag/digits outputs until the next acceptance clears them.
// -----------------------------------------------------------------------------
module mag_comp_seq
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 signed_mode,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 a_greater,
  output logic                                 a_equal,
  output logic                                 a_lesser,
  output logic [$clog2(WIDTH/DIGIT):0]         digits
);

  localparam int NDIG = WIDTH / DIGIT;
  // Slice index needs at least one bit even for a single-slice compare.
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [IW-1:0]    IDX_TOP  = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  // FSM state; kept as a named enum so checkers can bind to it directly.
  state_t            state;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;

  logic [DIGIT-1:0]  a_sl;
  logic [DIGIT-1:0]  b_sl;
  logic              sl_gt;
  logic              sl_eq;
  logic              sl_lt;
  res_t              sl_res;
  logic [WIDTH-1:0]  flip;

  // Inverting the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the slice datapath stays purely unsigned.
  assign flip = signed_mode ? MSB_MASK : '0;

  assign a_sl = a_q[int'(idx) * DIGIT +: DIGIT];
  assign b_sl = b_q[int'(idx) * DIGIT +: DIGIT];

  comp_digit #(
    .DIGIT (DIGIT)
  ) u_comp_digit (
    .a  (a_sl),
    .b  (b_sl),
    .gt (sl_gt),
    .eq (sl_eq),
    .lt (sl_lt)
  );

  assign sl_res = classify(sl_gt, sl_eq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_greater <= 1'b0;
      a_equal   <= 1'b0;
      a_lesser  <= 1'b0;
      digits    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q       <= a ^ flip;
            b_q       <= b ^ flip;
            idx       <= IDX_TOP;
            a_greater <= 1'b0;
            a_equal   <= 1'b0;
            a_lesser  <= 1'b0;
            digits    <= '0;
            busy      <= 1'b1;
            state     <= CMP;
          end
        end

        CMP: begin
          digits <= digits + 1'b1;
          case (sl_res)
            GT: begin
              a_greater <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
            LT: begin
              a_lesser <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end
            default: begin
              // Equal slice: decide only once the last slice matches.
              if (idx == '0) begin
                a_equal <= 1'b1;
                done    <= 1'b1;
                state   <= DONE;
              end else begin
                idx <= idx - 1'b1;
              end
            end
          endcase
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
// -----------------------------------------------------------------------------
// tb_mag_comp_seq
//   Self-checking bench for mag_comp_seq (WIDTH=16, DIGIT=4).
//   Expected results are pushed to exp_q when a compare is accepted and
//   popped by the monitor on every done pulse. Latency is counted with the
//   acceptance edge as cycle 1, so a top-slice decision reports 2.
// -----------------------------------------------------------------------------
module tb_mag_comp_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int DW    = $clog2(NDIG) + 1;
  localparam int EW    = 14;   // {flags[2:0], digits[2:0], latency[7:0]}

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             a_greater;
  logic             a_equal;
  logic             a_lesser;
  logic [DW-1:0]    digits;

  always #5 clk = ~clk;

  mag_comp_seq #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_greater   (a_greater),
    .a_equal     (a_equal),
    .a_lesser    (a_lesser),
    .digits      (digits)
  );

  // ---------------------------------------------------------------- scoreboard
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  int            done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("flags", int'({a_greater, a_equal, a_lesser}), int'(mon_e[13:11]));
        check("digits", int'(digits), int'(mon_e[10:8]));
        check("latency", cyc - accept_cyc + 1, int'(mon_e[7:0]));
        check("busy_at_done", int'(busy), 1);
      end
    end
  end

  // Reference: signed/unsigned ordering from SV operators, digits from the
  // position of the first differing nibble counted from the top.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic sm);
    logic [2:0] f;
    int         k;
    logic       found;
    k     = NDIG;
    found = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (!found && (x[i*DIGIT +: DIGIT] != y[i*DIGIT +: DIGIT])) begin
        k     = NDIG - i;
        found = 1'b1;
      end
    end
    if (sm) f = ($signed(x) > $signed(y)) ? 3'b100 : ((x == y) ? 3'b010 : 3'b001);
    else    f = (x > y) ? 3'b100 : ((x == y) ? 3'b010 : 3'b001);
    return {f, 3'(k), 8'(k + 1)};
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic sm, input logic [2:0] ef, input int ed);
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_q.push_back({ef, 3'(ed), 8'(ed + 1)});
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs after acceptance; the compare must not see them.
    a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    check("busy_in_cmp", int'(busy), 1);
    check("flags_clear", int'({a_greater, a_equal, a_lesser}), 0);
    check("digits_clear", int'(digits), 0);
    wait_done();
    check("busy_after", int'(busy), 0);
    check("flags_hold", int'({a_greater, a_equal, a_lesser}), int'(ef));
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic [2:0]       f;   // {gt, eq, lt}
    int               d;
  } vec_t;

  vec_t vt[9];

  initial begin
    int dc0;
    logic [WIDTH-1:0] x, y;
    logic             sm;
    logic [EW-1:0]    m;

    vt[0] = '{16'hA000, 16'h2000, 1'b0, 3'b100, 1};
    vt[1] = '{16'h1234, 16'h1234, 1'b0, 3'b010, 4};
    vt[2] = '{16'h1234, 16'h1235, 1'b0, 3'b001, 4};
    vt[3] = '{16'h8000, 16'h0001, 1'b1, 3'b001, 1};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 3'b100, 1};
    vt[5] = '{16'hFFFF, 16'h0000, 1'b1, 3'b001, 1};
    vt[6] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
    vt[7] = '{16'h0000, 16'h0000, 1'b1, 3'b010, 4};
    vt[8] = '{16'h1200, 16'h1300, 1'b0, 3'b001, 2};

    // Reset state.
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({a_greater, a_equal, a_lesser}), 0);
    check("rst_digits", int'(digits), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++)
      issue(vt[i].a, vt[i].b, vt[i].sm, vt[i].f, vt[i].d);

    // start pulsed twice while busy, operands changed mid-compare.
    @(negedge clk);
    a = 16'h00F0; b = 16'h00E0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_q.push_back({3'b100, 3'd3, 8'd4});
    dc0 = done_cnt;
    @(negedge clk);
    a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignored_start", int'(busy), 1);
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_test_done_count", done_cnt - dc0, 1);
    check("busy_test_busy_low", int'(busy), 0);
    check("busy_test_queue_empty", exp_q.size(), 0);
    exp_q.delete();

    // Reset asserted mid-compare.
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_flags", int'({a_greater, a_equal, a_lesser}), 0);
    check("midrst_digits", int'(digits), 0);
    dc0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_no_done", done_cnt - dc0, 0);
    check("post_rst_idle", int'(busy), 0);
    issue(16'h0000, 16'h8000, 1'b0, 3'b001, 1);

    // Random compares against the reference model.
    for (int i = 0; i < 24; i++) begin
      x  = 16'($urandom_range(0, 65535));
      sm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ (16'(1) << $urandom_range(0, 15));
        default: y = 16'($urandom_range(0, 65535));
      endcase
      m = model(x, y, sm);
      issue(x, y, sm, m[13:11], int'(m[10:8]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
